// File: rtl/trace_wr_pkg.sv
// Shared constants and FSM state type for the trace-to-memory writer.
package trace_wr_pkg;

  localparam int unsigned BPB          = 64;
  localparam logic [2:0]  AXSIZE       = 3'd6;
  localparam logic [1:0]  AXBURST_INCR = 2'b01;
  localparam logic [3:0]  AXCACHE      = 4'b0011;
  localparam logic [2:0]  AXPROT       = 3'b000;
  localparam logic [1:0]  BRESP_OKAY   = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_AW,
    ST_W,
    ST_B
  } wr_state_e;

endpackage

// File: rtl/trace_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count.
module trace_sync_fifo #(
  parameter int unsigned DATA_W = 512,
  parameter int unsigned DEPTH  = 16,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic [PTR_W:0]    count,
  output logic              full
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == (PTR_W + 1)'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && (count != '0);
  assign dout    = mem[rd_ptr];

  // Storage array; written only on an accepted push.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy tracking; push+pop in one cycle keeps count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/trace_axis_mem_writer.sv
// Buffers 512-bit trace beats and writes them as AXI4 INCR bursts into a ring buffer.
module trace_axis_mem_writer
  import trace_wr_pkg::*;
#(
  parameter int unsigned ADDR_W      = 36,
  parameter int unsigned DATA_W      = 512,
  parameter int unsigned BURST_BEATS = 8,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned SIZE_W      = 32
) (
  input  logic                aclk,
  input  logic                areset,
  input  logic                s_axis_tvalid,
  output logic                s_axis_tready,
  input  logic [DATA_W-1:0]   s_axis_tdata,
  input  logic [DATA_W/8-1:0] s_axis_tkeep,
  input  logic                s_axis_tlast,
  input  logic                ctrl_enable,
  input  logic                ctrl_clear,
  input  logic [ADDR_W-1:0]   ctrl_base,
  input  logic [SIZE_W-1:0]   ctrl_size,
  output logic [ADDR_W-1:0]   m_axi_awaddr,
  output logic [7:0]          m_axi_awlen,
  output logic [2:0]          m_axi_awsize,
  output logic [1:0]          m_axi_awburst,
  output logic [3:0]          m_axi_awcache,
  output logic [2:0]          m_axi_awprot,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  output logic [DATA_W-1:0]   m_axi_wdata,
  output logic [DATA_W/8-1:0] m_axi_wstrb,
  output logic                m_axi_wlast,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  input  logic [1:0]          m_axi_bresp,
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready,
  output logic [SIZE_W-1:0]   stat_wr_ptr,
  output logic [31:0]         stat_wrap_cnt,
  output logic [31:0]         stat_beats,
  output logic                stat_err
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned SHIFT = $clog2(DATA_W / 8);

  wr_state_e          state;
  wr_state_e          state_nx;
  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_full;
  logic               push;
  logic               pop;
  logic               run;
  logic               start;
  logic               commit;
  logic               flush_pending;
  logic               clear_pending;
  logic [7:0]         beat_cnt;
  logic [7:0]         burst_n;
  logic [7:0]         n_sel;
  logic [SIZE_W-1:0]  n_full;
  logic [SIZE_W-1:0]  room;
  logic [SIZE_W-1:0]  ptr_sum;
  logic               unused_bits;

  assign unused_bits   = ^{s_axis_tkeep, n_full[SIZE_W-1:8]};

  assign s_axis_tready = run && ctrl_enable && !fifo_full;
  assign push          = s_axis_tvalid && s_axis_tready;
  assign commit        = (state == ST_B) && m_axi_bvalid;
  assign room          = (ctrl_size - stat_wr_ptr) >> SHIFT;
  assign ptr_sum       = stat_wr_ptr + (SIZE_W'(burst_n) << SHIFT);

  assign m_axi_awsize  = AXSIZE;
  assign m_axi_awburst = AXBURST_INCR;
  assign m_axi_awcache = AXCACHE;
  assign m_axi_awprot  = AXPROT;
  assign m_axi_wstrb   = '1;

  trace_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (aclk),
    .rst   (areset),
    .push  (push),
    .din   (s_axis_tdata),
    .pop   (pop),
    .dout  (m_axi_wdata),
    .count (fifo_count),
    .full  (fifo_full)
  );

  // Burst length: limited by buffered beats, max burst and space left before the ring end.
  always_comb begin
    n_full = SIZE_W'(BURST_BEATS);
    if (SIZE_W'(fifo_count) < n_full) n_full = SIZE_W'(fifo_count);
    if (room < n_full) n_full = room;
    n_sel = n_full[7:0];
  end

  // State register.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // Next-state and AXI handshake outputs; one burst in flight at a time.
  always_comb begin
    state_nx      = state;
    start         = 1'b0;
    pop           = 1'b0;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_wlast   = 1'b0;
    m_axi_bready  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ctrl_enable && !ctrl_clear &&
            ((fifo_count >= CNT_W'(BURST_BEATS)) || (flush_pending && fifo_count != '0))) begin
          start    = 1'b1;
          state_nx = ST_AW;
        end
      end
      ST_AW: begin
        m_axi_awvalid = 1'b1;
        if (m_axi_awready) state_nx = ST_W;
      end
      ST_W: begin
        m_axi_wvalid = 1'b1;
        m_axi_wlast  = (beat_cnt == m_axi_awlen);
        pop          = m_axi_wready;
        if (m_axi_wready && m_axi_wlast) state_nx = ST_B;
      end
      ST_B: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Burst bookkeeping, flush tracking, ring pointer and status counters.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      run           <= 1'b0;
      m_axi_awaddr  <= '0;
      m_axi_awlen   <= '0;
      burst_n       <= '0;
      beat_cnt      <= '0;
      flush_pending <= 1'b0;
      clear_pending <= 1'b0;
      stat_wr_ptr   <= '0;
      stat_wrap_cnt <= '0;
      stat_beats    <= '0;
      stat_err      <= 1'b0;
    end else begin
      run <= 1'b1;
      if (start) begin
        m_axi_awaddr <= ctrl_base + ADDR_W'(stat_wr_ptr);
        m_axi_awlen  <= n_sel - 8'd1;
        burst_n      <= n_sel;
      end
      if (state == ST_AW && m_axi_awready) beat_cnt <= '0;
      else if (pop)                        beat_cnt <= beat_cnt + 8'd1;

      if (push && s_axis_tlast)               flush_pending <= 1'b1;
      else if (commit && fifo_count == '0)    flush_pending <= 1'b0;

      // A clear requested mid-burst is held and takes effect as the burst retires,
      // so the FSM re-enters IDLE with zeroed pointer and counters.
      if ((state == ST_IDLE && ctrl_clear) || (commit && (clear_pending || ctrl_clear))) begin
        clear_pending <= 1'b0;
        stat_wr_ptr   <= '0;
        stat_wrap_cnt <= '0;
        stat_beats    <= '0;
        stat_err      <= 1'b0;
      end else if (commit) begin
        stat_err   <= stat_err | (m_axi_bresp != BRESP_OKAY);
        stat_beats <= stat_beats + 32'(burst_n);
        if (ptr_sum == ctrl_size) begin
          stat_wr_ptr   <= '0;
          stat_wrap_cnt <= stat_wrap_cnt + 32'd1;
        end else begin
          stat_wr_ptr <= ptr_sum;
        end
      end else if (ctrl_clear) begin
        clear_pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_trace_axis_mem_writer.sv
// Directed bench for trace_axis_mem_writer with an AXI slave model and data scoreboard.
module tb_trace_axis_mem_writer;

  localparam int unsigned ADDR_W = 36;
  localparam int unsigned DATA_W = 512;
  localparam int unsigned SIZE_W = 32;

  logic                aclk;
  logic                areset;
  logic                s_axis_tvalid;
  logic                s_axis_tready;
  logic [DATA_W-1:0]   s_axis_tdata;
  logic [DATA_W/8-1:0] s_axis_tkeep;
  logic                s_axis_tlast;
  logic                ctrl_enable;
  logic                ctrl_clear;
  logic [ADDR_W-1:0]   ctrl_base;
  logic [SIZE_W-1:0]   ctrl_size;
  logic [ADDR_W-1:0]   m_axi_awaddr;
  logic [7:0]          m_axi_awlen;
  logic [2:0]          m_axi_awsize;
  logic [1:0]          m_axi_awburst;
  logic [3:0]          m_axi_awcache;
  logic [2:0]          m_axi_awprot;
  logic                m_axi_awvalid;
  logic                m_axi_awready;
  logic [DATA_W-1:0]   m_axi_wdata;
  logic [DATA_W/8-1:0] m_axi_wstrb;
  logic                m_axi_wlast;
  logic                m_axi_wvalid;
  logic                m_axi_wready;
  logic [1:0]          m_axi_bresp;
  logic                m_axi_bvalid;
  logic                m_axi_bready;
  logic [SIZE_W-1:0]   stat_wr_ptr;
  logic [31:0]         stat_wrap_cnt;
  logic [31:0]         stat_beats;
  logic                stat_err;

  trace_axis_mem_writer #(
    .ADDR_W      (36),
    .DATA_W      (512),
    .BURST_BEATS (8),
    .FIFO_DEPTH  (16),
    .SIZE_W      (32)
  ) dut (
    .aclk          (aclk),
    .areset        (areset),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tlast  (s_axis_tlast),
    .ctrl_enable   (ctrl_enable),
    .ctrl_clear    (ctrl_clear),
    .ctrl_base     (ctrl_base),
    .ctrl_size     (ctrl_size),
    .m_axi_awaddr  (m_axi_awaddr),
    .m_axi_awlen   (m_axi_awlen),
    .m_axi_awsize  (m_axi_awsize),
    .m_axi_awburst (m_axi_awburst),
    .m_axi_awcache (m_axi_awcache),
    .m_axi_awprot  (m_axi_awprot),
    .m_axi_awvalid (m_axi_awvalid),
    .m_axi_awready (m_axi_awready),
    .m_axi_wdata   (m_axi_wdata),
    .m_axi_wstrb   (m_axi_wstrb),
    .m_axi_wlast   (m_axi_wlast),
    .m_axi_wvalid  (m_axi_wvalid),
    .m_axi_wready  (m_axi_wready),
    .m_axi_bresp   (m_axi_bresp),
    .m_axi_bvalid  (m_axi_bvalid),
    .m_axi_bready  (m_axi_bready),
    .stat_wr_ptr   (stat_wr_ptr),
    .stat_wrap_cnt (stat_wrap_cnt),
    .stat_beats    (stat_beats),
    .stat_err      (stat_err)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int total = 0;
  int bad   = 0;

  logic [DATA_W-1:0] sb[$];
  logic [ADDR_W-1:0] exp_addr_q[$];
  logic [7:0]        exp_len_q[$];
  logic [1:0]        bresp_q[$];

  bit          aw_stall = 1'b0;
  bit          w_stall  = 1'b0;
  int          w_limit  = -1;
  int          b_pending = 0;
  bit          b_hs = 1'b0;
  logic [7:0]  cur_len = '0;
  int          wbeat = 0;
  int          aw_count = 0;
  int          w_count = 0;

  logic [ADDR_W-1:0] base = 36'h8_0000_0000;
  int unsigned       m_size = 4096;
  logic [31:0]       m_ptr = '0;
  logic [31:0]       m_wrap = '0;
  logic [31:0]       m_beats = '0;
  int unsigned       seq = 1;

  function automatic logic [DATA_W-1:0] mkbeat(input int unsigned s);
    logic [DATA_W-1:0] v;
    for (int unsigned k = 0; k < 16; k++) v[k*32 +: 32] = (s * 32'h9E37_79B1) ^ (k << 24) ^ s;
    return v;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected bursts for nb beats when all of them are buffered before the bursts drain.
  task automatic plan_bursts(input int unsigned nb);
    int unsigned rem, room, n;
    rem = nb;
    while (rem > 0) begin
      room = (m_size - m_ptr) / 64;
      n = rem;
      if (n > 8) n = 8;
      if (n > room) n = room;
      exp_addr_q.push_back(base + 36'(m_ptr));
      exp_len_q.push_back(8'(n - 1));
      m_ptr = m_ptr + 32'(n * 64);
      if (m_ptr == 32'(m_size)) begin
        m_ptr = '0;
        m_wrap = m_wrap + 1;
      end
      m_beats = m_beats + 32'(n);
      rem = rem - n;
    end
  endtask

  task automatic push_beat(input bit last);
    logic [DATA_W-1:0] d;
    int c;
    d = mkbeat(seq);
    seq++;
    s_axis_tdata  = d;
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    c = 0;
    while (s_axis_tready !== 1'b1 && c < 2000) begin
      @(negedge aclk);
      c++;
    end
    total++;
    assert (c < 2000) else begin
      bad++;
      $error("FAIL push_timeout: tready stuck at %0b expected 1", s_axis_tready);
    end
    if (c < 2000) sb.push_back(d);
    @(negedge aclk);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic push_n(input int unsigned n, input bit last_on_end);
    for (int unsigned i = 0; i < n; i++) push_beat(last_on_end && (i == n - 1));
  endtask

  task automatic wait_beats(input logic [31:0] target);
    int c;
    c = 0;
    while (stat_beats !== target && c < 3000) begin
      @(negedge aclk);
      c++;
    end
    check("wait_beats", 64'(stat_beats), 64'(target));
    repeat (2) @(negedge aclk);
  endtask

  task automatic pulse_clear();
    ctrl_clear = 1'b1;
    @(negedge aclk);
    ctrl_clear = 1'b0;
    @(negedge aclk);
    m_ptr = '0;
    m_wrap = '0;
    m_beats = '0;
  endtask

  // AXI slave model: drives ready/response on the falling edge and scores each handshake
  // that the following rising edge will complete.
  always @(negedge aclk) begin
    logic [ADDR_W-1:0] ea;
    logic [7:0]        el;
    logic [DATA_W-1:0] ed;
    if (areset) begin
      m_axi_awready = 1'b0;
      m_axi_wready  = 1'b0;
      m_axi_bvalid  = 1'b0;
      m_axi_bresp   = 2'b00;
      b_hs          = 1'b0;
      b_pending     = 0;
      wbeat         = 0;
    end else begin
      m_axi_awready = !aw_stall;
      m_axi_wready  = !w_stall && (w_limit != 0);
      if (b_hs) begin
        m_axi_bvalid = 1'b0;
        b_hs = 1'b0;
      end
      if (!m_axi_bvalid && b_pending > 0) begin
        m_axi_bvalid = 1'b1;
        m_axi_bresp  = (bresp_q.size() > 0) ? bresp_q.pop_front() : 2'b00;
        b_pending--;
      end
      if (m_axi_bvalid && m_axi_bready) b_hs = 1'b1;

      if (m_axi_awvalid && m_axi_awready) begin
        aw_count++;
        total++;
        assert (exp_addr_q.size() > 0) else begin
          bad++;
          $error("FAIL aw_extra: got awaddr %0h expected no burst", m_axi_awaddr);
        end
        if (exp_addr_q.size() > 0) begin
          ea = exp_addr_q.pop_front();
          el = exp_len_q.pop_front();
          total++;
          assert (m_axi_awaddr === ea) else begin
            bad++;
            $error("FAIL awaddr: got %0h expected %0h", m_axi_awaddr, ea);
          end
          total++;
          assert (m_axi_awlen === el) else begin
            bad++;
            $error("FAIL awlen: got %0d expected %0d", m_axi_awlen, el);
          end
        end
        total++;
        assert ({m_axi_awsize, m_axi_awburst, m_axi_awcache, m_axi_awprot} === 12'b110_01_0011_000) else begin
          bad++;
          $error("FAIL aw_const: got %0h expected %0h",
                 {m_axi_awsize, m_axi_awburst, m_axi_awcache, m_axi_awprot}, 12'b110_01_0011_000);
        end
        cur_len = m_axi_awlen;
        wbeat = 0;
      end

      if (m_axi_wvalid && m_axi_wready) begin
        w_count++;
        if (w_limit > 0) w_limit--;
        ed = (sb.size() > 0) ? sb.pop_front() : 'x;
        total++;
        assert (m_axi_wdata === ed) else begin
          bad++;
          $error("FAIL wdata: got %0h expected %0h", m_axi_wdata[63:0], ed[63:0]);
        end
        total++;
        assert (m_axi_wlast === (wbeat == int'(cur_len))) else begin
          bad++;
          $error("FAIL wlast: got %0b expected %0b at beat %0d", m_axi_wlast, (wbeat == int'(cur_len)), wbeat);
        end
        total++;
        assert (m_axi_wstrb === '1) else begin
          bad++;
          $error("FAIL wstrb: got %0h expected all ones", m_axi_wstrb);
        end
        if (wbeat == int'(cur_len)) begin
          b_pending++;
          wbeat = 0;
        end else begin
          wbeat++;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int aw_before;
    int w_before;
    areset        = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '1;
    s_axis_tlast  = 1'b0;
    ctrl_enable   = 1'b1;
    ctrl_clear    = 1'b0;
    ctrl_base     = base;
    ctrl_size     = 32'(m_size);
    #1;
    check("rst_tready",  64'(s_axis_tready), 64'(0));
    check("rst_awvalid", 64'(m_axi_awvalid), 64'(0));
    check("rst_wvalid",  64'(m_axi_wvalid),  64'(0));
    check("rst_wlast",   64'(m_axi_wlast),   64'(0));
    check("rst_bready",  64'(m_axi_bready),  64'(0));
    check("rst_awaddr",  64'(m_axi_awaddr),  64'(0));
    check("rst_awlen",   64'(m_axi_awlen),   64'(0));
    check("rst_stats",   64'({stat_wr_ptr, stat_err}), 64'(0));
    check("rst_counts",  {stat_wrap_cnt, stat_beats}, 64'(0));
    repeat (3) @(negedge aclk);
    areset = 1'b0;
    repeat (2) @(negedge aclk);

    // Two full bursts from the ring base.
    plan_bursts(16);
    push_n(16, 1'b0);
    wait_beats(m_beats);
    check("t1_ptr", 64'(stat_wr_ptr), 64'h400);

    // Flush of a short record after a clear.
    pulse_clear();
    check("clr_ptr", 64'(stat_wr_ptr), 64'h0);
    plan_bursts(3);
    push_n(3, 1'b1);
    wait_beats(m_beats);
    check("t2_ptr", 64'(stat_wr_ptr), 64'hC0);

    // Advance to 0xFC0, then a record that must be split across the ring end.
    plan_bursts(60);
    push_n(60, 1'b1);
    wait_beats(m_beats);
    check("t3_ptr_pre", 64'(stat_wr_ptr), 64'hFC0);
    plan_bursts(8);
    push_n(8, 1'b1);
    wait_beats(m_beats);
    check("t3_wrap_ptr", 64'(stat_wr_ptr), 64'h1C0);
    check("t3_wrap_cnt", 64'(stat_wrap_cnt), 64'd1);

    // Memory side stalled while 20 beats are offered.
    aw_stall = 1'b1;
    w_stall  = 1'b1;
    plan_bursts(20);
    push_n(16, 1'b0);
    s_axis_tdata  = mkbeat(seq);
    s_axis_tvalid = 1'b1;
    repeat (34) @(negedge aclk);
    check("bp_tready", 64'(s_axis_tready), 64'(0));
    check("bp_awvalid", 64'(m_axi_awvalid), 64'(1));
    aw_stall = 1'b0;
    w_stall  = 1'b0;
    push_n(3, 1'b0);
    push_beat(1'b1);
    wait_beats(m_beats);
    check("bp_sb_empty", 64'(sb.size()), 64'(0));
    check("bp_ptr", 64'(stat_wr_ptr), 64'(m_ptr));

    // Sticky error response.
    bresp_q.push_back(2'b10);
    plan_bursts(8);
    push_n(8, 1'b0);
    wait_beats(m_beats);
    check("err_set", 64'(stat_err), 64'(1));
    plan_bursts(8);
    push_n(8, 1'b0);
    wait_beats(m_beats);
    check("err_sticky", 64'(stat_err), 64'(1));
    pulse_clear();
    check("err_clr", 64'(stat_err), 64'(0));
    check("clr_counts", {stat_wrap_cnt, stat_beats}, 64'(0));

    // Asynchronous reset in the middle of a data phase.
    w_limit = 3;
    w_before = w_count;
    plan_bursts(8);
    push_n(8, 1'b0);
    for (int i = 0; i < 200 && w_count < w_before + 3; i++) @(negedge aclk);
    check("mid_w_beats", 64'(w_count - w_before), 64'(3));
    repeat (2) @(negedge aclk);
    check("mid_w_wvalid", 64'(m_axi_wvalid), 64'(1));
    #2;
    areset = 1'b1;
    #1;
    check("arst_wvalid",  64'(m_axi_wvalid),  64'(0));
    check("arst_awvalid", 64'(m_axi_awvalid), 64'(0));
    check("arst_wlast",   64'(m_axi_wlast),   64'(0));
    check("arst_bready",  64'(m_axi_bready),  64'(0));
    check("arst_tready",  64'(s_axis_tready), 64'(0));
    check("arst_stats",   {stat_wrap_cnt, stat_beats}, 64'(0));
    @(negedge aclk);
    sb.delete();
    exp_addr_q.delete();
    exp_len_q.delete();
    bresp_q.delete();
    w_limit = -1;
    m_ptr = '0;
    m_wrap = '0;
    m_beats = '0;
    @(negedge aclk);
    areset = 1'b0;
    aw_before = aw_count;
    repeat (20) @(negedge aclk);
    check("post_rst_no_aw", 64'(aw_count - aw_before), 64'(0));
    check("post_rst_awvalid", 64'(m_axi_awvalid), 64'(0));
    plan_bursts(8);
    push_n(8, 1'b0);
    wait_beats(m_beats);
    check("post_rst_ptr", 64'(stat_wr_ptr), 64'h200);
    check("final_sb_empty", 64'(sb.size()), 64'(0));
    check("final_aw_empty", 64'(exp_addr_q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
